// File: rtl/rgb_pwm_encoder_if.sv
// Control and pin bundle for rgb_pwm_encoder.
// The master drives run/load/duties; the slave (encoder) drives the PWM pins and status.
interface rgb_pwm_encoder_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             load;
    logic [CNT_W-1:0] r_duty;
    logic [CNT_W-1:0] g_duty;
    logic [CNT_W-1:0] b_duty;
    logic             pwm_r;
    logic             pwm_g;
    logic             pwm_b;
    logic             period_start;
    logic             pending;
    logic             busy;

    modport master (
        output en, load, r_duty, g_duty, b_duty,
        input  pwm_r, pwm_g, pwm_b, period_start, pending, busy
    );

    modport slave (
        input  en, load, r_duty, g_duty, b_duty,
        output pwm_r, pwm_g, pwm_b, period_start, pending, busy
    );
endinterface

// File: rtl/rgb_pwm_encoder.sv
// Three-channel PWM encoder with double-buffered duties that switch only at period boundaries.
// Define PWM_ACTIVE_LOW_EN for common-anode LEDs (pins inverted, inactive/reset level 1).
module rgb_pwm_encoder #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned PERIOD = 255
) (
    input logic              clk_div,
    input logic              rst,
    rgb_pwm_encoder_if.slave bus
);

`ifdef PWM_ACTIVE_LOW_EN
    localparam logic PwmOn  = 1'b0;
    localparam logic PwmOff = 1'b1;
`else
    localparam logic PwmOn  = 1'b1;
    localparam logic PwmOff = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [2:0][CNT_W-1:0]       staged_q, staged_d;
    logic [2:0][CNT_W-1:0]       shadow_q, shadow_d;
    logic                        pending_q, pending_d;
    logic [2:0]                  pwm_q, pwm_d;
    logic                        period_start_q, period_start_d;
    logic [2:0][CNT_W-1:0]       duty_in;
    logic                        wrap;
    logic                        start;

    assign duty_in = {bus.b_duty, bus.g_duty, bus.r_duty};
    assign wrap    = (state_q != StIdle) && (cnt_q == CntLast);
    assign start   = (state_q == StIdle) && bus.en;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        staged_d       = staged_q;
        shadow_d       = shadow_q;
        pending_d      = pending_q;
        pwm_d          = {3{PwmOff}};
        period_start_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus.en) state_d = StRun;
            end
            StRun: begin
                cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
                if (!bus.en) state_d = StDrain;
            end
            StDrain: begin
                cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
                // A re-raised en wins over finishing the drain; cnt keeps counting.
                if (bus.en) state_d = StRun;
                else if (wrap) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (bus.load) begin
            staged_d  = duty_in;
            pending_d = 1'b1;
        end

        // Shadow update points: start of a run and every period wrap.
        // A coincident load bypasses staging so it is not deferred a full period.
        if (start || wrap) begin
            if (bus.load) shadow_d = duty_in;
            else if (start || pending_q) shadow_d = staged_q;
            pending_d = 1'b0;
        end

        if (state_q != StIdle) begin
            for (int i = 0; i < 3; i++) begin
                pwm_d[i] = (cnt_q < shadow_q[i]) ? PwmOn : PwmOff;
            end
            period_start_d = (cnt_q == '0);
        end
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            staged_q       <= '0;
            shadow_q       <= '0;
            pending_q      <= 1'b0;
            pwm_q          <= {3{PwmOff}};
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            staged_q       <= staged_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign bus.pwm_r        = pwm_q[0];
    assign bus.pwm_g        = pwm_q[1];
    assign bus.pwm_b        = pwm_q[2];
    assign bus.period_start = period_start_q;
    assign bus.pending      = pending_q;
    assign bus.busy         = (state_q != StIdle);

endmodule
